// File: rtl/prog_clk_div.sv
// prog_clk_div: programmable clock divider. It produces a registered divided
// clock and a start-of-period tick. A new ratio is loaded through a pending
// register and takes effect only at a period boundary, so no period is ever
// truncated or stretched.
//
// Ports:
//   signal_i  - clock to be divided; all state updates on its rising edge
//   reset_i   - asynchronous, active-low reset
//   enable_i  - 1 = run, 0 = hold idle (counter cleared, outputs low)
//   div_i     - requested divide ratio N
//   load_i    - one-cycle strobe that captures div_i as the pending ratio
//   div_o     - divided clock: high for ceil(N/2) cycles, then low for the rest
//   tick_o    - one-cycle pulse in the first cycle of each output period
//   pending_o - a captured ratio is waiting for the next period boundary
//   ratio_o   - the active ratio N
module prog_clk_div #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 8
) (
  input  logic             signal_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] div_i,
  input  logic             load_i,
  output logic             div_o,
  output logic             tick_o,
  output logic             pending_o,
  output logic [WIDTH-1:0] ratio_o
);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] pend_val;

  logic             boundary;
  logic [WIDTH-1:0] n_next;
  logic [WIDTH:0]   h_cur;
  logic [WIDTH-1:0] cnt_inc;

  // H and N-1 are formed one bit wider than the ratio so that
  // N = 2^WIDTH-1 neither overflows H nor aliases the wrap compare.
  always_comb begin
    boundary = 1'b0;
    n_next   = ratio_o;
    h_cur    = '0;
    cnt_inc  = '0;

    h_cur   = ({1'b0, ratio_o} + ONE) >> 1;
    cnt_inc = cnt + WIDTH'(1);

    // A period starts on the first enabled edge, at every wrap, and on every
    // edge while stopped at N = 0 (so a pending ratio is picked up at once).
    boundary = (state == ST_IDLE) || (ratio_o == '0) ||
               ({1'b0, cnt} == ({1'b0, ratio_o} - ONE));

    // A load sampled on the boundary edge governs the period it starts.
    if (load_i) begin
      n_next = div_i;
    end else if (pending_o) begin
      n_next = pend_val;
    end else begin
      n_next = ratio_o;
    end
  end

  always_ff @(posedge signal_i or negedge reset_i) begin
    if (!reset_i) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      div_o     <= 1'b0;
      tick_o    <= 1'b0;
      pending_o <= 1'b0;
      pend_val  <= '0;
      ratio_o   <= WIDTH'(DEFAULT_DIV);
    end else if (!enable_i) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      div_o  <= 1'b0;
      tick_o <= 1'b0;
      if (load_i) begin
        pend_val  <= div_i;
        pending_o <= 1'b1;
      end
    end else begin
      state <= ST_RUN;
      if (load_i) begin
        pend_val <= div_i;
      end
      if (boundary) begin
        ratio_o   <= n_next;
        pending_o <= 1'b0;
        cnt       <= '0;
        div_o     <= (n_next != '0);
        tick_o    <= (n_next != '0);
      end else begin
        cnt    <= cnt_inc;
        div_o  <= ({1'b0, cnt_inc} < h_cur);
        tick_o <= 1'b0;
        if (load_i) begin
          pending_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_clk_div.sv
// tb_prog_clk_div: directed bench for prog_clk_div (WIDTH = 8, DEFAULT_DIV = 8).
// A vector table covers the opening periods edge by edge; hand-written
// sequences cover the multi-cycle corner cases.
module tb_prog_clk_div;

  logic       signal_i;
  logic       reset_i;
  logic       enable_i;
  logic [7:0] div_i;
  logic       load_i;
  logic       div_o;
  logic       tick_o;
  logic       pending_o;
  logic [7:0] ratio_o;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  prog_clk_div #(
    .WIDTH       (8),
    .DEFAULT_DIV (8)
  ) dut (
    .signal_i  (signal_i),
    .reset_i   (reset_i),
    .enable_i  (enable_i),
    .div_i     (div_i),
    .load_i    (load_i),
    .div_o     (div_o),
    .tick_o    (tick_o),
    .pending_o (pending_o),
    .ratio_o   (ratio_o)
  );

  initial signal_i = 1'b0;
  always #5 signal_i = ~signal_i;

  // One record per rising edge: inputs sampled at that edge, outputs after it.
  typedef struct {
    logic       en;
    logic       ld;
    logic [7:0] d;
    logic       ediv;
    logic       etick;
    logic       epend;
    logic [7:0] eratio;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic en, input logic ld, input logic [7:0] d,
                              input logic ediv, input logic etick, input logic epend,
                              input logic [7:0] eratio);
    vec_t v;
    v.en = en; v.ld = ld; v.d = d;
    v.ediv = ediv; v.etick = etick; v.epend = epend; v.eratio = eratio;
    vecs.push_back(v);
  endfunction

  function automatic void addn(input int unsigned n, input logic ediv, input logic epend,
                               input logic [7:0] eratio);
    for (int unsigned i = 0; i < n; i++) add(1'b1, 1'b0, 8'd0, ediv, 1'b0, epend, eratio);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step(input logic en, input logic ld, input logic [7:0] d);
    enable_i = en;
    load_i   = ld;
    div_i    = d;
    @(posedge signal_i);
    #1;
    load_i = 1'b0;
  endtask

  task automatic wait_tick(input string name, input int unsigned bound);
    int unsigned n;
    n = 0;
    do begin
      step(1'b1, 1'b0, 8'd0);
      n++;
    end while (!tick_o && n < bound);
    chk(name, 32'(tick_o), 32'd1);
  endtask

  // Called in a tick cycle; walks one full period and lands in the next tick.
  task automatic check_period(input string name, input int unsigned h, input int unsigned l);
    int unsigned hi;
    int unsigned lo;
    int unsigned xtick;
    int unsigned order_ok;
    hi = 1; lo = 0; xtick = 0; order_ok = 1;
    for (int unsigned i = 1; i < h + l; i++) begin
      step(1'b1, 1'b0, 8'd0);
      if (div_o) begin
        if (lo != 0) order_ok = 0;
        hi++;
      end else begin
        lo++;
      end
      if (tick_o) xtick++;
    end
    chk({name, "_high"}, hi, h);
    chk({name, "_low"}, lo, l);
    chk({name, "_order"}, order_ok, 32'd1);
    chk({name, "_extra_tick"}, xtick, 32'd0);
    step(1'b1, 1'b0, 8'd0);
    chk({name, "_next_tick"}, 32'(tick_o), 32'd1);
    chk({name, "_next_div"}, 32'(div_o), 32'd1);
  endtask

  initial begin
    reset_i  = 1'b0;
    enable_i = 1'b1;
    load_i   = 1'b0;
    div_i    = 8'd0;

    // Divide-by-8 from reset: two clean periods, load 5 at cnt = 2.
    add(1, 0, 0, 1, 1, 0, 8);
    addn(3, 1, 0, 8);
    addn(4, 0, 0, 8);
    add(1, 0, 0, 1, 1, 0, 8);
    addn(2, 1, 0, 8);
    add(1, 1, 5, 1, 0, 1, 8);
    addn(4, 0, 1, 8);
    // Ratio 5: 3 high / 2 low.
    add(1, 0, 0, 1, 1, 0, 5);
    addn(2, 1, 0, 5);
    addn(2, 0, 0, 5);
    add(1, 0, 0, 1, 1, 0, 5);
    addn(2, 1, 0, 5);
    addn(2, 0, 0, 5);
    // Load 3 in the last cycle of the period: governs the next period.
    add(1, 1, 3, 1, 1, 0, 3);
    addn(1, 1, 0, 3);
    addn(1, 0, 0, 3);
    add(1, 0, 0, 1, 1, 0, 3);
    // Two loads in one period: last one (10) wins.
    add(1, 1, 6, 1, 0, 1, 3);
    add(1, 1, 10, 0, 0, 1, 3);
    add(1, 0, 0, 1, 1, 0, 10);
    addn(4, 1, 0, 10);
    addn(5, 0, 0, 10);
    add(1, 0, 0, 1, 1, 0, 10);

    // Reset state, with the clock running and enable_i already high.
    #500;
    chk("rst_div", 32'(div_o), 32'd0);
    chk("rst_tick", 32'(tick_o), 32'd0);
    chk("rst_pend", 32'(pending_o), 32'd0);
    chk("rst_ratio", 32'(ratio_o), 32'd8);
    #500;
    reset_i = 1'b1;

    for (int unsigned i = 0; i < vecs.size(); i++) begin
      step(vecs[i].en, vecs[i].ld, vecs[i].d);
      chk($sformatf("vec%0d_div", i), 32'(div_o), 32'(vecs[i].ediv));
      chk($sformatf("vec%0d_tick", i), 32'(tick_o), 32'(vecs[i].etick));
      chk($sformatf("vec%0d_pend", i), 32'(pending_o), 32'(vecs[i].epend));
      chk($sformatf("vec%0d_ratio", i), 32'(ratio_o), 32'(vecs[i].eratio));
    end

    // N = 1: continuous high, tick every cycle.
    step(1'b1, 1'b1, 8'd1);
    chk("n1_pend", 32'(pending_o), 32'd1);
    wait_tick("n1_reach", 20);
    chk("n1_ratio", 32'(ratio_o), 32'd1);
    chk("n1_pend_clr", 32'(pending_o), 32'd0);
    for (int unsigned i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 8'd0);
      chk("n1_div", 32'(div_o), 32'd1);
      chk("n1_tick", 32'(tick_o), 32'd1);
    end

    // N = 0: output stopped.
    step(1'b1, 1'b1, 8'd0);
    chk("n0_ratio", 32'(ratio_o), 32'd0);
    for (int unsigned i = 0; i < 3; i++) begin
      chk("n0_div", 32'(div_o), 32'd0);
      chk("n0_tick", 32'(tick_o), 32'd0);
      step(1'b1, 1'b0, 8'd0);
    end

    // Restart from N = 0 with ratio 4: applies on the next edge.
    step(1'b1, 1'b1, 8'd4);
    chk("n4_div", 32'(div_o), 32'd1);
    chk("n4_tick", 32'(tick_o), 32'd1);
    chk("n4_ratio", 32'(ratio_o), 32'd4);
    chk("n4_pend", 32'(pending_o), 32'd0);
    check_period("n4", 2, 2);

    // Largest ratio for WIDTH = 8.
    step(1'b1, 1'b1, 8'd255);
    chk("n255_pend", 32'(pending_o), 32'd1);
    wait_tick("n255_reach", 10);
    chk("n255_ratio", 32'(ratio_o), 32'd255);
    check_period("n255", 128, 127);

    // Disable mid high phase, load while disabled, re-enable.
    step(1'b1, 1'b0, 8'd0);
    step(1'b1, 1'b0, 8'd0);
    chk("pre_dis_div", 32'(div_o), 32'd1);
    step(1'b0, 1'b1, 8'd6);
    chk("dis_div", 32'(div_o), 32'd0);
    chk("dis_tick", 32'(tick_o), 32'd0);
    chk("dis_pend", 32'(pending_o), 32'd1);
    chk("dis_ratio", 32'(ratio_o), 32'd255);
    step(1'b0, 1'b0, 8'd0);
    chk("dis_hold_div", 32'(div_o), 32'd0);
    step(1'b1, 1'b0, 8'd0);
    chk("en_tick", 32'(tick_o), 32'd1);
    chk("en_div", 32'(div_o), 32'd1);
    chk("en_ratio", 32'(ratio_o), 32'd6);
    chk("en_pend", 32'(pending_o), 32'd0);
    check_period("n6", 3, 3);

    // Asynchronous reset mid high phase with a load pending.
    step(1'b1, 1'b1, 8'd2);
    chk("prerst_pend", 32'(pending_o), 32'd1);
    chk("prerst_div", 32'(div_o), 32'd1);
    #2 reset_i = 1'b0;
    #1;
    chk("arst_div", 32'(div_o), 32'd0);
    chk("arst_tick", 32'(tick_o), 32'd0);
    chk("arst_pend", 32'(pending_o), 32'd0);
    chk("arst_ratio", 32'(ratio_o), 32'd8);
    #2 reset_i = 1'b1;
    step(1'b1, 1'b0, 8'd0);
    chk("post_rst_tick", 32'(tick_o), 32'd1);
    chk("post_rst_div", 32'(div_o), 32'd1);
    chk("post_rst_ratio", 32'(ratio_o), 32'd8);
    check_period("post_rst", 4, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_clk_div.md
PROG_CLK_DIV -- requirements
Module: prog_clk_div

Interface
REQ-001 SHALL have parameter WIDTH, default 8: width of the divide ratio and the period counter.
REQ-002 SHALL have parameter DEFAULT_DIV, default 8: active ratio loaded at reset (divide-by-8 behaviour out of reset).
REQ-003 SHALL have port signal_i, input, 1: single clock (the signal to be divided); all state updates on its rising edge.
REQ-004 SHALL have port reset_i, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port enable_i, input, 1: 1 = run, 0 = hold in idle.
REQ-006 SHALL have port div_i, input, WIDTH: requested divide ratio N.
REQ-007 SHALL have port load_i, input, 1: one-cycle strobe that captures div_i as the pending ratio.
REQ-008 SHALL have port div_o, output, 1: registered divided clock.
REQ-009 SHALL have port tick_o, output, 1: registered one-cycle pulse marking the first cycle of each output period.
REQ-010 SHALL have port pending_o, output, 1: a captured ratio is waiting for the next period boundary.
REQ-011 SHALL have port ratio_o, output, WIDTH: the active ratio N.

Function
REQ-012 SHALL run an internal counter cnt over 0..N-1 while enabled; cnt wraps from N-1 to 0, and each wrap is a period boundary.
REQ-013 SHALL, for N >= 2, hold div_o high for H = ceil(N/2) cycles and low for N-H cycles per period, with div_o high in the cycle tick_o is high.
REQ-014 SHALL compute H and N-1 in WIDTH+1 bits; N = 2^WIDTH-1 SHALL work without overflow.
REQ-015 SHALL, for N = 1, hold div_o high continuously and assert tick_o every enabled cycle.
REQ-016 SHALL, for N = 0, hold div_o low and tick_o low (output stopped); cnt held at 0; pending loads are still accepted.
REQ-017 SHALL, when a pending ratio exists and N = 0, apply it on the next enabled cycle.
REQ-018 SHALL make the first rising edge after reset release, or after enable_i rises, start a period: div_o = 1 and tick_o = 1 after that edge.
REQ-019 SHALL, on load_i, capture div_i into a pending register and set pending_o on the following cycle.
REQ-020 SHALL let a later load_i before the boundary overwrite the pending value (last load wins).
REQ-021 SHALL apply the pending ratio at the next period boundary: the new period uses the new N from its first cycle, ratio_o updates in that same cycle, and pending_o clears.
REQ-022 SHALL let the current period complete at the old ratio; no truncated or stretched periods are permitted.
REQ-023 SHALL, when load_i is asserted in the last cycle of a period (cnt = N-1), make the new ratio govern the immediately following period.
REQ-024 SHALL, when enable_i = 0, clear cnt to 0 and drive div_o = 0 and tick_o = 0, while still accepting load_i.
REQ-025 SHALL, when a pending ratio exists while disabled, apply it on the first enabled cycle.
REQ-026 SHALL, when enable_i falls mid-period, take div_o low on the next edge; the partial period is discarded.

Reset
REQ-027 SHALL, on reset_i = 0, immediately (without waiting for a clock edge) set cnt = 0, div_o = 0, tick_o = 0, pending_o = 0, pending register = 0 and ratio_o = DEFAULT_DIV.
REQ-028 SHALL, when reset is asserted mid-period or with a load pending, discard the pending load and abandon the partial period.
REQ-029 SHALL tolerate reset_i deasserting asynchronously; the first enabled edge after release behaves per REQ-018.

Verification
REQ-030 SHALL cover: reset held 1000 ns, then release with enable_i = 1 and no load -> div_o 4 cycles high / 4 low, tick_o every 8 cycles, ratio_o = 8.
REQ-031 SHALL cover: load_i with div_i = 5 at cnt = 2 of a divide-by-8 period -> that period completes at 8 cycles; subsequent periods are 3 high / 2 low; pending_o is high from load+1 until the boundary.
REQ-032 SHALL cover: load_i with div_i = 3 exactly at cnt = N-1 -> the next period is 2 high / 1 low; two loads (6, then 10) in one period -> only 10 is applied.
REQ-033 SHALL cover: div_i = 1 -> div_o constantly 1 and tick_o every cycle; then div_i = 0 -> div_o = 0 and tick_o = 0 after the boundary; then div_i = 4 -> output restarts the next cycle at 2 high / 2 low.
REQ-034 SHALL cover: WIDTH = 8 with div_i = 255 -> 128 high / 127 low, tick_o period 255.
REQ-035 SHALL cover: reset_i pulsed low mid-high-phase with a load pending -> div_o = 0 immediately without a clock edge, pending_o = 0, ratio_o = 8 after release.
